vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised raster timing generator, the successor to the fixed-geometry sync generator. It produces hsync/vsync with configurable polarity, beam position, blanking flags, line/frame strobes and a frame counter. It sits between the pixel clock and every pattern/sprite renderer in the design. An internal pixel-clock divider and an external advance enable let one system clock drive any mode.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- H_WIDTH, 10, width of hpos; must hold H_TOTAL-1
- V_WIDTH, 10, width of vpos; must hold V_TOTAL-1
- FRAME_WIDTH, 8, width of frame_count
- CLK_DIV, 1, system clocks per pixel (>=1)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  1  advance enable; low freezes divider and counters
- hpos  out  H_WIDTH  current column, 0..H_TOTAL-1
- vpos  out  V_WIDTH  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync at HSYNC_POL level when active
- vsync  out  1  vertical sync at VSYNC_POL level when active
- display_on  out  1  hpos<H_DISPLAY and vpos<V_DISPLAY
- hblank  out  1  hpos>=H_DISPLAY
- vblank  out  1  vpos>=V_DISPLAY
- pix_tick  out  1  one-clk strobe; counters advance at this edge
- line_start  out  1  one-clk pulse when hpos wraps to 0
- frame_start  out  1  one-clk pulse when hpos and vpos both wrap to 0
- frame_count  out  FRAME_WIDTH  completed frames, modulo 2^FRAME_WIDTH

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK. V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK.
- Line order: display, front porch, sync, back porch. Frame order: the same.
- hsync is active for H_DISPLAY+H_FRONT <= hpos <= H_DISPLAY+H_FRONT+H_SYNC-1. vsync uses the same rule on vpos with V_ parameters.
- Divider: div counts 0..CLK_DIV-1, incrementing only when en=1. pix_tick = en and (div==CLK_DIV-1). div wraps to 0 on pix_tick. When CLK_DIV=1, pix_tick = en.
- On pix_tick:
  - hpos increments, and wraps to 0 after H_TOTAL-1.
  - On hpos wrap, vpos increments, and wraps to 0 after V_TOTAL-1.
  - On vpos wrap, frame_count increments, wrapping modulo 2^FRAME_WIDTH.
- en low: div, hpos, vpos, frame_count and all decoded outputs hold. pix_tick, line_start and frame_start are 0.
- All decoded outputs are registered, computed from next-state counter values. They are therefore exactly aligned with the hpos/vpos values present in the same cycle, with no one-cycle lag.
- line_start is 1 in the cycle where hpos==0 following a wrap. frame_start is 1 in the cycle where hpos==0 and vpos==0 following a wrap. Both are 1 for exactly one clk regardless of CLK_DIV.
- Entering (0,0) by reset does not raise line_start or frame_start.

## Timing
- Reset values, asserted asynchronously:
  - div=0, hpos=0, vpos=0, frame_count=0
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL
  - display_on=1, hblank=0, vblank=0
  - pix_tick=0, line_start=0, frame_start=0
- First pix_tick occurs CLK_DIV enabled clocks after reset release.
- Position latency is zero: decodes change on the same edge as hpos/vpos.
- Reset mid-frame: state returns to the reset values immediately, with no partial pulse. Counting restarts from (0,0).
- en deasserted mid-divide: div holds its partial count. The tick fires after the remaining enabled clocks.
- hpos and vpos wrap on the same edge: line_start and frame_start both pulse, and frame_count increments on that edge.

## Test plan
- Defaults, en=1, CLK_DIV=1:
  - hsync=0 exactly for hpos 656..751 (96 clks); line period 800 clks.
  - vsync=0 for vpos 490..491.
  - frame_start every 420000 clks; frame_count 0->1 at the first wrap.
- Small mode (H 4/1/2/1, V 3/1/1/1, HSYNC_POL=1, VSYNC_POL=1):
  - H_TOTAL=8, V_TOTAL=6.
  - hsync=1 at hpos 5..6; vsync=1 at vpos 4; display_on only for hpos<4, vpos<3.
  - frame_start every 48 clks.
- CLK_DIV=4, small mode:
  - hpos changes every 4 clks.
  - pix_tick is a 1-clk pulse every 4 clks.
  - line_start is 1 clk wide, every 32 clks.
- en toggled in a 1-on/2-off pattern with CLK_DIV=1: hpos advances only on en=1 clocks, and pulses are absent while en=0.
- Assert reset at hpos=5, vpos=2 in small mode:
  - Outputs go to reset values asynchronously, before the next clk edge.
  - No frame_start occurs.
  - After release, hpos=1 after the first enabled clk.
- FRAME_WIDTH=2, small mode: after 4 frames, frame_count wraps 3->0 on the same edge as frame_start.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel divider, beam counters and
// registered sync/blank/strobe decodes aligned with the hpos/vpos they describe.
module vga_timing_gen #(
  parameter int   H_DISPLAY   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_DISPLAY   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic HSYNC_POL   = 1'b0,
  parameter logic VSYNC_POL   = 1'b0,
  parameter int   H_WIDTH     = 10,
  parameter int   V_WIDTH     = 10,
  parameter int   FRAME_WIDTH = 8,
  parameter int   CLK_DIV     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  output logic [H_WIDTH-1:0]     hpos,
  output logic [V_WIDTH-1:0]     vpos,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   display_on,
  output logic                   hblank,
  output logic                   vblank,
  output logic                   pix_tick,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_WIDTH-1:0] frame_count
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]       div_q, div_d;
  logic [H_WIDTH-1:0]     hpos_q, hpos_d;
  logic [V_WIDTH-1:0]     vpos_q, vpos_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic disp_q, disp_d, hblank_q, hblank_d, vblank_q, vblank_d;
  logic pix_tick_q, pix_tick_d, line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;
  logic tick, h_wrap, v_wrap;

  always_comb begin
    tick    = en && (div_q == DIV_W'(CLK_DIV - 1));
    h_wrap  = (hpos_q == H_WIDTH'(H_TOTAL - 1));
    v_wrap  = (vpos_q == V_WIDTH'(V_TOTAL - 1));
    div_d   = div_q;
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    frame_d = frame_q;

    if (en) div_d = tick ? '0 : div_q + DIV_W'(1);

    if (tick) begin
      if (h_wrap) begin
        hpos_d = '0;
        if (v_wrap) begin
          vpos_d  = '0;
          frame_d = frame_q + FRAME_WIDTH'(1);
        end else begin
          vpos_d = vpos_q + V_WIDTH'(1);
        end
      end else begin
        hpos_d = hpos_q + H_WIDTH'(1);
      end
    end

    // Decode from next-state counters so the registered flags line up with hpos/vpos.
    hsync_d  = ((hpos_d >= H_WIDTH'(HS_START)) && (hpos_d <= H_WIDTH'(HS_END))) ?
               HSYNC_POL : ~HSYNC_POL;
    vsync_d  = ((vpos_d >= V_WIDTH'(VS_START)) && (vpos_d <= V_WIDTH'(VS_END))) ?
               VSYNC_POL : ~VSYNC_POL;
    hblank_d = (hpos_d >= H_WIDTH'(H_DISPLAY));
    vblank_d = (vpos_d >= V_WIDTH'(V_DISPLAY));
    disp_d   = !hblank_d && !vblank_d;

    pix_tick_d    = tick;
    line_start_d  = tick && h_wrap;
    frame_start_d = tick && h_wrap && v_wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      frame_q       <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      disp_q        <= 1'b1;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      pix_tick_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_q       <= frame_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      disp_q        <= disp_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      pix_tick_q    <= pix_tick_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame_count = frame_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = disp_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign pix_tick    = pix_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Four generator configurations driven in lockstep and compared each cycle against
// an arithmetic raster model derived from the count of enabled clocks since reset.
module tb_vga_timing_gen;

  localparam int N = 4;
  // 0: default VGA; 1: small mode; 2: small mode, CLK_DIV=4; 3: small mode, FRAME_WIDTH=2
  localparam int HD[N]  = '{640, 4, 4, 4};
  localparam int HF[N]  = '{16, 1, 1, 1};
  localparam int HS[N]  = '{96, 2, 2, 2};
  localparam int HB[N]  = '{48, 1, 1, 1};
  localparam int VD[N]  = '{480, 3, 3, 3};
  localparam int VF[N]  = '{10, 1, 1, 1};
  localparam int VS[N]  = '{2, 1, 1, 1};
  localparam int VB[N]  = '{33, 1, 1, 1};
  localparam int POL[N] = '{0, 1, 1, 1};
  localparam int DIV[N] = '{1, 1, 4, 1};
  localparam int FW[N]  = '{8, 8, 8, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic [9:0] hp[N];
  logic [9:0] vp[N];
  logic [7:0] fc[N];
  logic hsy[N], vsy[N], dsp[N], hbl[N], vbl[N], ptk[N], lst[N], fst[N];

  int total = 0;
  int bad   = 0;

  longint ecnt[N];
  bit     tk[N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [FW[g]-1:0] fc_w;
    vga_timing_gen #(
      .H_DISPLAY(HD[g]), .H_FRONT(HF[g]), .H_SYNC(HS[g]), .H_BACK(HB[g]),
      .V_DISPLAY(VD[g]), .V_FRONT(VF[g]), .V_SYNC(VS[g]), .V_BACK(VB[g]),
      .HSYNC_POL(POL[g] != 0), .VSYNC_POL(POL[g] != 0),
      .H_WIDTH(10), .V_WIDTH(10), .FRAME_WIDTH(FW[g]), .CLK_DIV(DIV[g])
    ) u_dut (
      .clk(clk), .reset(rst), .en(en),
      .hpos(hp[g]), .vpos(vp[g]),
      .hsync(hsy[g]), .vsync(vsy[g]),
      .display_on(dsp[g]), .hblank(hbl[g]), .vblank(vbl[g]),
      .pix_tick(ptk[g]), .line_start(lst[g]), .frame_start(fst[g]),
      .frame_count(fc_w)
    );
    assign fc[g] = 8'(fc_w);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string phase);
    for (int i = 0; i < N; i++) begin
      longint ticks, ht, vt, h, v, f;
      bit hs_on, vs_on, ls;
      string p;
      p     = $sformatf("%s d%0d", phase, i);
      ht    = HD[i] + HF[i] + HS[i] + HB[i];
      vt    = VD[i] + VF[i] + VS[i] + VB[i];
      ticks = ecnt[i] / DIV[i];
      h     = ticks % ht;
      v     = (ticks / ht) % vt;
      f     = (ticks / (ht * vt)) % (64'd1 << FW[i]);
      hs_on = (h >= HD[i] + HF[i]) && (h < HD[i] + HF[i] + HS[i]);
      vs_on = (v >= VD[i] + VF[i]) && (v < VD[i] + VF[i] + VS[i]);
      ls    = tk[i] && (h == 0);
      chk({p, " hpos"}, hp[i], h);
      chk({p, " vpos"}, vp[i], v);
      chk({p, " frame_count"}, fc[i], f);
      chk({p, " hsync"}, hsy[i], hs_on ? POL[i] : 1 - POL[i]);
      chk({p, " vsync"}, vsy[i], vs_on ? POL[i] : 1 - POL[i]);
      chk({p, " display_on"}, dsp[i], (h < HD[i]) && (v < VD[i]));
      chk({p, " hblank"}, hbl[i], h >= HD[i]);
      chk({p, " vblank"}, vbl[i], v >= VD[i]);
      chk({p, " pix_tick"}, ptk[i], tk[i]);
      chk({p, " line_start"}, lst[i], ls);
      chk({p, " frame_start"}, fst[i], ls && (v == 0));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ecnt[i] = 0;
      tk[i]   = 1'b0;
    end
  endtask

  // Called at a negedge; returns at the following negedge after checking.
  task automatic step(input bit en_v, input string phase);
    en = en_v;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (en_v) begin
        ecnt[i]++;
        tk[i] = (ecnt[i] % DIV[i]) == 0;
      end else begin
        tk[i] = 1'b0;
      end
    end
    @(negedge clk);
    check_all(phase);
  endtask

  // Raise reset between edges so the asynchronous clear is observed before any clock.
  task automatic do_reset(input string phase);
    rst = 1'b1;
    #1;
    model_reset();
    check_all({phase, " async"});
    @(posedge clk);
    @(negedge clk);
    check_all({phase, " held"});
    rst = 1'b0;
  endtask

  initial begin
    int clkcnt, hscnt, fcnt;
    bit seen_ls, seen_fs, found;

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Free-running: line period and hsync width on the default mode, frame period on small mode.
    seen_ls = 0; seen_fs = 0; clkcnt = 0; hscnt = 0; fcnt = 0;
    for (int k = 0; k < 2000; k++) begin
      step(1'b1, "run");
      if (lst[0]) begin
        if (seen_ls) begin
          chk("d0 line period", clkcnt, 800);
          chk("d0 hsync width", hscnt, 96);
        end
        seen_ls = 1; clkcnt = 0; hscnt = 0;
      end
      clkcnt++;
      if (!hsy[0]) hscnt++;
      if (fst[1]) begin
        if (seen_fs) chk("d1 frame period", fcnt, 48);
        seen_fs = 1; fcnt = 0;
      end
      fcnt++;
    end

    for (int k = 0; k < 300; k++) step((k % 3) == 0, "en1of3");

    for (int k = 0; k < 2000; k++) step($urandom_range(0, 3) != 0, "rand");

    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      step(1'b1, "seek");
      found = (hp[1] == 5) && (vp[1] == 2);
    end
    chk("seek h5v2 reached", found, 1);
    do_reset("midframe");
    step(1'b1, "after_rst");
    chk("d1 hpos after release", hp[1], 1);

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
      else step($urandom_range(0, 4) != 0, "rand2");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
